// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: two-port arbiter/sequencer in front of a single-port register
// file whose f_we=1 cycle loads the address and whose f_we=0 cycle writes fin
// into the addressed entry. Each granted transaction becomes a SEL (address
// load) cycle followed by an ACC (data) cycle. Outside a write's ACC cycle the
// file's own output is looped back onto fin so its contents are preserved.
module reg_file_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_sel,
    output logic [DATA_W-1:0] rf_fin,
    input  logic [DATA_W-1:0] rf_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SEL, ACC} state_t;

    state_t              state_q, state_d;
    logic                op_wr_q, op_wr_d;     // latched op: 1 = write
    logic [DATA_W-1:0]   wdata_q, wdata_d;     // latched write data
    logic                port_q, port_d;       // port owning the transaction
    logic                prio_q, prio_d;       // round-robin: port favoured on a tie
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_sel_q, rf_sel_d;   // doubles as the latched address
    logic                busy_q, busy_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                win;                  // arbitration winner (0/1)

    // Arbitration: tie broken by mode; a lone requester always wins
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = (PRIO_MODE == 1) ? 1'b0 : prio_q;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    // Next-state, grant and registered-output next values
    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        wdata_d   = wdata_q;
        port_d    = port_q;
        prio_d    = prio_q;
        rf_we_d   = 1'b0;
        rf_sel_d  = rf_sel_q;
        busy_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0     = ~win;
                    gnt1     = win;
                    port_d   = win;
                    prio_d   = ~win;
                    op_wr_d  = win ? wr1 : wr0;
                    wdata_d  = win ? wdata1 : wdata0;
                    rf_sel_d = win ? addr1 : addr0;
                    rf_we_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SEL;
                end
            end
            SEL: begin
                busy_d  = 1'b1;
                state_d = ACC;
            end
            ACC: begin
                // Read data is on rf_out during ACC; capture it on the closing edge
                if (!op_wr_q) begin
                    if (port_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = rf_out;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = rf_out;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            wdata_q   <= '0;
            port_q    <= 1'b0;
            prio_q    <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_sel_q  <= '0;
            busy_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            wdata_q   <= wdata_d;
            port_q    <= port_d;
            prio_q    <= prio_d;
            rf_we_q   <= rf_we_d;
            rf_sel_q  <= rf_sel_d;
            busy_q    <= busy_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // fin carries write data only in a write's ACC cycle; otherwise it refreshes
    assign rf_fin  = (state_q == ACC && op_wr_q) ? wdata_q : rf_out;
    assign rf_we   = rf_we_q;
    assign rf_sel  = rf_sel_q;
    assign busy    = busy_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: behavioural register file attached to the DUT, a
// transaction-level reference model checked every cycle, a table of directed
// transactions, hand-written corner sequences and a randomized phase. A second
// instance in fixed-priority mode is used for the starvation check.
module tb_reg_file_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req0, wr0, req1, wr1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, rf_we, busy;
    logic [7:0] rdata0, rdata1, rf_fin, rf_out;
    logic [4:0] rf_sel;

    // fixed-priority instance
    logic       req0_p, req1_p;
    logic       gnt0_p, gnt1_p, rvalid0_p, rvalid1_p, rf_we_p, busy_p;
    logic [7:0] rdata0_p, rdata1_p, rf_fin_p, rf_out_p;
    logic [4:0] rf_sel_p;

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_ctrl #(.ADDR_W(5), .DATA_W(8), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rf_we(rf_we), .rf_sel(rf_sel), .rf_fin(rf_fin), .rf_out(rf_out),
        .busy(busy)
    );

    assign rf_out_p = 8'h00;
    reg_file_ctrl #(.ADDR_W(5), .DATA_W(8), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_p), .wr0(1'b0), .addr0(5'd4), .wdata0(8'h00),
        .gnt0(gnt0_p), .rvalid0(rvalid0_p), .rdata0(rdata0_p),
        .req1(req1_p), .wr1(1'b0), .addr1(5'd9), .wdata1(8'h00),
        .gnt1(gnt1_p), .rvalid1(rvalid1_p), .rdata1(rdata1_p),
        .rf_we(rf_we_p), .rf_sel(rf_sel_p), .rf_fin(rf_fin_p), .rf_out(rf_out_p),
        .busy(busy_p)
    );

    // ---------------- register file attached to the DUT ----------------
    logic [7:0] fmem [32];
    logic [4:0] fsel_q;
    logic       load_init;

    function automatic logic [7:0] init_val(int i);
        logic [7:0] v;
        v = 8'(i * 37 + 17);
        return v;
    endfunction

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 32; i++) fmem[i] <= init_val(i);
            fsel_q <= 5'd0;
        end else if (rf_we) begin
            fsel_q <= rf_sel;
        end else begin
            fmem[fsel_q] <= rf_fin;
        end
    end
    assign rf_out = fmem[fsel_q];

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int         due;
        bit         port;
        bit         wr;
        logic [4:0] addr;
        logic [7:0] data;
    } pend_t;

    pend_t      pq[$];
    logic [7:0] ref_mem [32];
    int         cyc, next_grant, grant_cyc;
    bit         m_prio;
    bit         cur_wr;
    logic [4:0] cur_addr;
    logic [7:0] cur_wdata;
    logic [7:0] exp_rdata0, exp_rdata1;
    bit         g0_last, g1_last;
    // DUT samples from the latest cycle
    logic       d_g0, d_g1, d_rv0;
    logic       p_g0, p_g1, p_rv0, p_rv1, p_busy, p_we;
    logic [4:0] p_sel;
    logic [7:0] p_rd0, p_rd1, p_fin;
    int         cnt_gnt1, cnt_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        cyc        = 0;
        next_grant = 0;
        grant_cyc  = -100;
        m_prio     = 1'b0;
        exp_rdata0 = 8'h00;
        exp_rdata1 = 8'h00;
        g0_last    = 1'b0;
        g1_last    = 1'b0;
    endtask

    // Evaluate one cycle at the falling edge: retire, arbitrate, compare
    task automatic model_and_check();
        bit    e_rv0, e_rv1, w;
        pend_t p;
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        while (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            if (p.wr) begin
                ref_mem[p.addr] = p.data;
            end else if (p.port) begin
                e_rv1 = 1'b1;
                exp_rdata1 = ref_mem[p.addr];
            end else begin
                e_rv0 = 1'b1;
                exp_rdata0 = ref_mem[p.addr];
            end
            $display("txn port=%0d %s addr=%0d data=%02h", p.port, p.wr ? "wr" : "rd", p.addr,
                     p.wr ? p.data : ref_mem[p.addr]);
        end
        g0_last = 1'b0;
        g1_last = 1'b0;
        if (cyc >= next_grant && (req0 || req1)) begin
            w = (req0 && req1) ? m_prio : !req0;
            g0_last    = !w;
            g1_last    = w;
            m_prio     = !w;
            next_grant = cyc + 3;
            grant_cyc  = cyc;
            cur_wr     = w ? wr1 : wr0;
            cur_addr   = w ? addr1 : addr0;
            cur_wdata  = w ? wdata1 : wdata0;
            pq.push_back('{cyc + 3, w, cur_wr, cur_addr, cur_wdata});
        end
        chk("gnt0", gnt0, g0_last);
        chk("gnt1", gnt1, g1_last);
        chk("rvalid0", rvalid0, e_rv0);
        chk("rvalid1", rvalid1, e_rv1);
        chk("rdata0", rdata0, exp_rdata0);
        chk("rdata1", rdata1, exp_rdata1);
        chk("busy", busy, (cyc == grant_cyc + 1) || (cyc == grant_cyc + 2));
        chk("rf_we", rf_we, cyc == grant_cyc + 1);
        if (cyc == grant_cyc + 1) chk("rf_sel", rf_sel, cur_addr);
        chk("rf_fin", rf_fin, (cyc == grant_cyc + 2 && cur_wr) ? cur_wdata : rf_out);
        cyc++;
    endtask

    // Called just after a rising edge with this cycle's inputs already driven
    task automatic run_cycle();
        @(negedge clk);
        d_g0 = gnt0; d_g1 = gnt1; d_rv0 = rvalid0;
        p_g0 = gnt0_p; p_g1 = gnt1_p; p_rv0 = rvalid0_p; p_rv1 = rvalid1_p;
        p_busy = busy_p; p_we = rf_we_p; p_sel = rf_sel_p;
        p_rd0 = rdata0_p; p_rd1 = rdata1_p; p_fin = rf_fin_p;
        cnt_gnt1 += int'(gnt1);
        cnt_busy += int'(busy);
        model_and_check();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit port, input bit r, input bit w, input logic [4:0] a,
                           input logic [7:0] d);
        if (port) begin
            req1 = r; wr1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; wr0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Issue one transaction, wait for its grant and completion
    task automatic do_txn(input bit port, input bit w, input logic [4:0] a, input logic [7:0] d,
                          output logic [7:0] rd);
        bit got;
        got = 1'b0;
        set_req(port, 1'b1, w, a, d);
        for (int k = 0; k < 12 && !got; k++) begin
            run_cycle();
            got = port ? g1_last : g0_last;
        end
        if (!got) chk("gnt_wait", 32'd0, 32'd1);
        set_req(port, 1'b0, w, a, d);
        for (int k = 0; k < 3; k++) run_cycle();
        rd = port ? rdata1 : rdata0;
    endtask

    typedef struct {
        bit         port;
        bit         wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] rd;
    int         order[$];
    bit         got;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 5'd3,  8'hA5, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'hA5};
        tbl[2] = '{1'b1, 1'b1, 5'd31, 8'hFF, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hFF};
        tbl[4] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5};
        tbl[5] = '{1'b0, 1'b1, 5'd0,  8'h00, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h00};
        tbl[7] = '{1'b1, 1'b1, 5'd2,  8'h11, 8'h00};

        rst_n = 1'b0; load_init = 1'b1;
        req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        req0_p = 0; req1_p = 0;
        cnt_gnt1 = 0; cnt_busy = 0;
        model_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

        // reset values
        repeat (2) @(posedge clk);
        #1 load_init = 1'b0;
        @(negedge clk);
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata0", rdata0, 8'h00);
        chk("rst_rdata1", rdata1, 8'h00);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rf_sel", rf_sel, 5'd0);
        chk("rst_rf_fin", rf_fin, rf_out);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        run_cycle();

        // directed table
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        // back-to-back write then read of addr 3 on port 0
        set_req(0, 1, 1, 5'd3, 8'hA5);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin run_cycle(); got = d_g0; end
        if (!got) chk("t1_gnt_wait", 32'd0, 32'd1);
        set_req(0, 1, 0, 5'd3, 8'h00);
        run_cycle(); chk("t1_no_gnt_sel", d_g0, 1'b0);
        run_cycle(); chk("t1_no_gnt_acc", d_g0, 1'b0);
        run_cycle(); chk("t1_gnt_T3", d_g0, 1'b1);
        set_req(0, 0, 0, 5'd3, 8'h00);
        run_cycle(); run_cycle();
        run_cycle(); chk("t1_rvalid_T6", d_rv0, 1'b1);
        chk("t1_rdata", rdata0, 8'hA5);

        // write then long idle: loop-back must keep contents
        do_txn(0, 1, 5'd7, 8'h3C, rd);
        for (int k = 0; k < 20; k++) run_cycle();
        do_txn(0, 0, 5'd7, 8'h00, rd);
        chk("t3_rdata", rd, 8'h3C);
        chk("t3_mem7", fmem[7], 8'h3C);

        // reset during ACC of a write of 0x55 to addr 2 (holds 0x11)
        set_req(0, 1, 1, 5'd2, 8'h55);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin run_cycle(); got = g0_last; end
        set_req(0, 0, 1, 5'd2, 8'h55);
        run_cycle();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_rf_we", rf_we, 1'b0);
        chk("t5_rf_fin", rf_fin, rf_out);
        chk("t5_rvalid0", rvalid0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        chk("t5_mem2", fmem[2], 8'h11);
        run_cycle(); run_cycle();

        // both ports requesting: round-robin order from reset
        set_req(0, 1, 0, 5'd5, 8'h00);
        set_req(1, 1, 0, 5'd6, 8'h00);
        for (int k = 0; k < 20 && order.size() < 4; k++) begin
            run_cycle();
            if (d_g0) order.push_back(0);
            if (d_g1) order.push_back(1);
        end
        set_req(0, 0, 0, 5'd5, 8'h00);
        set_req(1, 0, 0, 5'd6, 8'h00);
        chk("t2_grant_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk($sformatf("t2_order%0d", i), order[i], i % 2);
        for (int k = 0; k < 4; k++) run_cycle();
        do_txn(0, 0, 5'd2, 8'h00, rd);
        chk("t5_rdata_after_rst", rd, 8'h11);

        // fixed-priority instance: port 0 always wins, port 1 starves
        req0_p = 1'b1; req1_p = 1'b1;
        for (int k = 0; k < 12; k++) begin
            run_cycle();
            chk("p_gnt0", p_g0, (k % 3) == 0);
            chk("p_gnt1", p_g1, 1'b0);
            chk("p_busy", p_busy, (k % 3) != 0);
            chk("p_rf_we", p_we, (k % 3) == 1);
            if ((k % 3) == 1) chk("p_rf_sel", p_sel, 5'd4);
            chk("p_rvalid0", p_rv0, (k % 3) == 0 && k > 0);
            chk("p_rvalid1", p_rv1, 1'b0);
            chk("p_rdata", {p_rd0, p_rd1, p_fin}, 24'h0);
        end
        req0_p = 1'b0; req1_p = 1'b0;

        // read held through a busy period: one grant, 2 busy cycles per txn
        set_req(0, 1, 1, 5'd9, 8'h77);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin run_cycle(); got = g0_last; end
        set_req(0, 0, 1, 5'd9, 8'h77);
        set_req(1, 1, 0, 5'd9, 8'h00);
        cnt_gnt1 = 0; cnt_busy = 0;
        for (int k = 0; k < 8; k++) begin
            run_cycle();
            if (d_g1) set_req(1, 0, 0, 5'd9, 8'h00);
        end
        set_req(1, 0, 0, 5'd9, 8'h00);
        chk("t6_gnt1_once", cnt_gnt1, 1);
        chk("t6_busy_cycles", cnt_busy, 4);
        chk("t6_rdata1", rdata1, 8'h77);

        // randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            if (g0_last) req0 = 1'b0;
            if (g1_last) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 2) == 0)
                set_req(0, 1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                        8'($urandom_range(0, 255)));
            if (!req1 && $urandom_range(0, 2) == 0)
                set_req(1, 1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                        8'($urandom_range(0, 255)));
            run_cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 6; k++) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
